// File: rtl/grid_pkg.sv
// Shared cell/state encodings, button indices and colour codes for the grid game.
package grid_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    GS_PLAY = 2'b00,
    GS_WIN  = 2'b01,
    GS_DRAW = 2'b10
  } game_state_t;

  localparam int NUM_BTN    = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  // {R,G,B}
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_GRID   = 3'b100;
  localparam logic [2:0] COL_CURSOR = 3'b010;
  localparam logic [2:0] COL_P1     = 3'b001;
  localparam logic [2:0] COL_P2     = 3'b110;

  function automatic cell_t player_cell(input logic player);
    return player ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/grid_game_board_vga_btn_edge_sampler.sv
// Button front end: two-flop synchroniser, sampling prescaler and rising-edge detect.
module btn_edge_sampler #(
  parameter int WIDTH    = 5,
  parameter int DEB_BITS = 18
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0]    sync1_reg;
  logic [WIDTH-1:0]    sync2_reg;
  logic [WIDTH-1:0]    sampled_reg;
  logic [DEB_BITS-1:0] presc_reg;
  logic                tick;

  assign tick = &presc_reg;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sampled_reg <= '0;
      presc_reg   <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      presc_reg <= presc_reg + 1'b1;
      if (tick)
        sampled_reg <= sync2_reg;
    end
  end

  // The value about to be sampled, compared against the previous sample, only on the tick.
  assign press = {WIDTH{tick}} & sync2_reg & ~sampled_reg;

endmodule

// File: rtl/grid_game_board_vga.sv
// NxN two-player grid game: button-driven cursor, marking, win/draw detection and VGA rendering.
module grid_game_board_vga
  import grid_pkg::*;
#(
  parameter int GRID_N   = 3,
  parameter int CELL_PX  = 120,
  parameter int ORIGIN_X = 60,
  parameter int ORIGIN_Y = 60,
  parameter int BORDER   = 3,
  parameter int DEB_BITS = 18
) (
  input  logic                      board_clk,
  input  logic                      reset,
  input  logic                      pix_ce,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  input  logic                      in_display,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_center,
  output logic                      vga_r,
  output logic                      vga_g,
  output logic                      vga_b,
  output logic [$clog2(GRID_N)-1:0] cursor_row,
  output logic [$clog2(GRID_N)-1:0] cursor_col,
  output logic                      cur_player,
  output logic [1:0]                game_state,
  output logic                      winner
);

  localparam int IDXW = $clog2(GRID_N);
  localparam int NC   = GRID_N * GRID_N;
  localparam int CW   = $clog2(NC);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(GRID_N - 1);
  localparam logic [9:0] NEAR_LO = 10'(BORDER);
  localparam logic [9:0] NEAR_HI = 10'(CELL_PX - BORDER);
  localparam logic [9:0] MARK_LO = 10'(2 * BORDER);
  localparam logic [9:0] MARK_HI = 10'(CELL_PX - 2 * BORDER);

  logic [NUM_BTN-1:0] btn_press;

  btn_edge_sampler #(.WIDTH(NUM_BTN), .DEB_BITS(DEB_BITS)) u_btn (
    .board_clk (board_clk),
    .reset     (reset),
    .btn_raw   ({btn_center, btn_right, btn_left, btn_down, btn_up}),
    .press     (btn_press)
  );

  game_state_t     state_reg, state_next;
  cell_t           board_reg [NC];
  logic [IDXW-1:0] row_reg, col_reg;
  logic            player_reg, last_mover_reg, winner_reg, eval_reg;
  logic            do_mark, do_clear, mv_up, mv_down, mv_left, mv_right;
  logic [CW-1:0]   cur_idx;

  assign cur_idx = CW'(row_reg) * CW'(GRID_N) + CW'(col_reg);

  // Ownership maps, plus a transposed copy so columns become contiguous slices.
  logic [NC-1:0]     own_p1, own_p2, own_p1_t, own_p2_t;
  logic [GRID_N-1:0] row_w1, row_w2, col_w1, col_w2, dg_1, dg_2, ad_1, ad_2;
  logic              win_any, board_full;

  genvar gi, gj;
  generate
    for (gi = 0; gi < GRID_N; gi++) begin : g_row
      for (gj = 0; gj < GRID_N; gj++) begin : g_col
        assign own_p1[gi*GRID_N+gj]   = (board_reg[gi*GRID_N+gj] == CELL_P1);
        assign own_p2[gi*GRID_N+gj]   = (board_reg[gi*GRID_N+gj] == CELL_P2);
        assign own_p1_t[gj*GRID_N+gi] = (board_reg[gi*GRID_N+gj] == CELL_P1);
        assign own_p2_t[gj*GRID_N+gi] = (board_reg[gi*GRID_N+gj] == CELL_P2);
      end
      assign row_w1[gi] = &own_p1[gi*GRID_N +: GRID_N];
      assign row_w2[gi] = &own_p2[gi*GRID_N +: GRID_N];
      assign col_w1[gi] = &own_p1_t[gi*GRID_N +: GRID_N];
      assign col_w2[gi] = &own_p2_t[gi*GRID_N +: GRID_N];
      assign dg_1[gi]   = own_p1[gi*GRID_N+gi];
      assign dg_2[gi]   = own_p2[gi*GRID_N+gi];
      assign ad_1[gi]   = own_p1[gi*GRID_N+GRID_N-1-gi];
      assign ad_2[gi]   = own_p2[gi*GRID_N+GRID_N-1-gi];
    end
  endgenerate

  assign win_any = (|row_w1) | (|row_w2) | (|col_w1) | (|col_w2)
                 | (&dg_1) | (&dg_2) | (&ad_1) | (&ad_2);
  assign board_full = &(own_p1 | own_p2);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) state_reg <= GS_PLAY;
    else       state_reg <= state_next;
  end

  // eval_reg marks the clock after a board write, when the new board is settled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GS_PLAY: begin
        if (eval_reg && win_any)         state_next = GS_WIN;
        else if (eval_reg && board_full) state_next = GS_DRAW;
      end
      GS_WIN, GS_DRAW: begin
        if (btn_press[BTN_CENTER]) state_next = GS_PLAY;
      end
      default: state_next = GS_PLAY;
    endcase
  end

  always_comb begin
    do_mark  = 1'b0;
    do_clear = 1'b0;
    mv_up    = 1'b0;
    mv_down  = 1'b0;
    mv_left  = 1'b0;
    mv_right = 1'b0;
    if (state_reg == GS_PLAY) begin
      if (btn_press[BTN_CENTER])     do_mark  = (board_reg[cur_idx] == CELL_EMPTY);
      else if (btn_press[BTN_UP])    mv_up    = 1'b1;
      else if (btn_press[BTN_DOWN])  mv_down  = 1'b1;
      else if (btn_press[BTN_LEFT])  mv_left  = 1'b1;
      else if (btn_press[BTN_RIGHT]) mv_right = 1'b1;
    end else begin
      do_clear = btn_press[BTN_CENTER];
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) board_reg[i] <= CELL_EMPTY;
      row_reg        <= '0;
      col_reg        <= '0;
      player_reg     <= 1'b0;
      last_mover_reg <= 1'b0;
      winner_reg     <= 1'b0;
      eval_reg       <= 1'b0;
    end else begin
      eval_reg <= do_mark;
      if (do_clear) begin
        for (int i = 0; i < NC; i++) board_reg[i] <= CELL_EMPTY;
        row_reg    <= '0;
        col_reg    <= '0;
        player_reg <= 1'b0;
      end else begin
        if (do_mark) begin
          board_reg[cur_idx] <= player_cell(player_reg);
          player_reg         <= ~player_reg;
          last_mover_reg     <= player_reg;
        end
        if (mv_up)    row_reg <= (row_reg == '0)      ? LAST_IDX : row_reg - 1'b1;
        if (mv_down)  row_reg <= (row_reg == LAST_IDX) ? '0       : row_reg + 1'b1;
        if (mv_left)  col_reg <= (col_reg == '0)      ? LAST_IDX : col_reg - 1'b1;
        if (mv_right) col_reg <= (col_reg == LAST_IDX) ? '0       : col_reg + 1'b1;
      end
      if (state_reg == GS_PLAY && eval_reg && win_any)
        winner_reg <= last_mover_reg;
    end
  end

  assign cursor_row = row_reg;
  assign cursor_col = col_reg;
  assign cur_player = player_reg;
  assign game_state = state_reg;
  assign winner     = winner_reg;

  // Pixel path: boundary comparators locate the cell and the offset inside it.
  logic [9:0]      bx [GRID_N+1];
  logic [9:0]      by [GRID_N+1];
  logic [GRID_N:0] x_on, y_on;

  generate
    for (gi = 0; gi <= GRID_N; gi++) begin : g_bound
      assign bx[gi]   = 10'(ORIGIN_X + gi * CELL_PX);
      assign by[gi]   = 10'(ORIGIN_Y + gi * CELL_PX);
      assign x_on[gi] = (pix_x == bx[gi]);
      assign y_on[gi] = (pix_y == by[gi]);
    end
  endgenerate

  logic [IDXW-1:0] pcol, prow;
  logic [9:0]      x_left, y_top, x_off, y_off;
  logic            x_span, y_span, x_in, y_in;
  logic            grid_hit, cursor_hit, mark_hit;
  cell_t           pix_cell;
  logic [2:0]      colour, rgb_reg;

  always_comb begin
    pcol   = '0;
    prow   = '0;
    x_left = bx[0];
    y_top  = by[0];
    for (int k = 1; k < GRID_N; k++) begin
      if (pix_x >= bx[k]) begin
        pcol   = IDXW'(k);
        x_left = bx[k];
      end
      if (pix_y >= by[k]) begin
        prow  = IDXW'(k);
        y_top = by[k];
      end
    end
  end

  assign x_off    = pix_x - x_left;
  assign y_off    = pix_y - y_top;
  assign x_span   = (pix_x >= bx[0]) && (pix_x <= bx[GRID_N]);
  assign y_span   = (pix_y >= by[0]) && (pix_y <= by[GRID_N]);
  assign x_in     = (pix_x > bx[0]) && (pix_x < bx[GRID_N]) && !(|x_on);
  assign y_in     = (pix_y > by[0]) && (pix_y < by[GRID_N]) && !(|y_on);
  assign pix_cell = board_reg[CW'(prow) * CW'(GRID_N) + CW'(pcol)];

  assign grid_hit   = ((|x_on) && y_span) || ((|y_on) && x_span);
  assign cursor_hit = x_in && y_in && (prow == row_reg) && (pcol == col_reg)
                    && ((x_off <= NEAR_LO) || (x_off >= NEAR_HI)
                     || (y_off <= NEAR_LO) || (y_off >= NEAR_HI));
  assign mark_hit   = x_in && y_in && (pix_cell != CELL_EMPTY)
                    && (x_off >= MARK_LO) && (x_off <= MARK_HI)
                    && (y_off >= MARK_LO) && (y_off <= MARK_HI);

  always_comb begin
    colour = COL_BLACK;
    if (grid_hit)        colour = COL_GRID;
    else if (cursor_hit) colour = COL_CURSOR;
    else if (mark_hit)   colour = (pix_cell == CELL_P1) ? COL_P1 : COL_P2;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset)       rgb_reg <= COL_BLACK;
    else if (pix_ce) rgb_reg <= in_display ? colour : COL_BLACK;
  end

  assign {vga_r, vga_g, vga_b} = rgb_reg;

endmodule

// File: tb/tb_grid_game_board_vga.sv
// Directed bench for the grid game: cursor, marking, win/draw, pixel colours and async reset.
module tb_grid_game_board_vga;

  localparam logic [4:0] B_UP     = 5'b00001;
  localparam logic [4:0] B_DOWN   = 5'b00010;
  localparam logic [4:0] B_LEFT   = 5'b00100;
  localparam logic [4:0] B_RIGHT  = 5'b01000;
  localparam logic [4:0] B_CENTER = 5'b10000;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_ce = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       in_display = 1'b0;
  logic [4:0] btns = '0;
  logic       vga_r, vga_g, vga_b;
  logic [1:0] cursor_row, cursor_col;
  logic       cur_player, winner;
  logic [1:0] game_state;

  int total = 0;
  int bad = 0;
  int cr = 0;
  int cc = 0;

  grid_game_board_vga #(
    .GRID_N(3), .CELL_PX(120), .ORIGIN_X(60), .ORIGIN_Y(60), .BORDER(3), .DEB_BITS(2)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .in_display (in_display),
    .btn_up     (btns[0]),
    .btn_down   (btns[1]),
    .btn_left   (btns[2]),
    .btn_right  (btns[3]),
    .btn_center (btns[4]),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .cur_player (cur_player),
    .game_state (game_state),
    .winner     (winner)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold buttons until the sampler emits a press; returns on the negedge of the pulse cycle.
  task automatic hold(input logic [4:0] m);
    bit seen;
    seen = 1'b0;
    btns = m;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge board_clk);
      if (dut.btn_press != 5'b0) seen = 1'b1;
    end
    chk("pulse_seen", 32'(seen), 32'd1);
  endtask

  task automatic release_btns();
    btns = '0;
    repeat (12) @(negedge board_clk);
  endtask

  task automatic tap(input logic [4:0] m);
    hold(m);
    release_btns();
  endtask

  task automatic goto_cell(input int r, input int c);
    while (cr != r) begin tap(B_DOWN);  cr = (cr + 1) % 3; end
    while (cc != c) begin tap(B_RIGHT); cc = (cc + 1) % 3; end
  endtask

  task automatic mark(input int r, input int c);
    goto_cell(r, c);
    tap(B_CENTER);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic d, input logic [2:0] exp);
    @(negedge board_clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
    in_display = d;
    pix_ce = 1'b1;
    @(negedge board_clk);
    pix_ce = 1'b0;
    chk(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
  endtask

  int dr [9] = '{0, 0, 0, 1, 1, 2, 1, 2, 2};
  int dc [9] = '{0, 1, 2, 0, 1, 0, 2, 2, 1};

  initial begin
    repeat (3) @(negedge board_clk);
    chk("rst_row", 32'(cursor_row), 0);
    chk("rst_col", 32'(cursor_col), 0);
    chk("rst_player", 32'(cur_player), 0);
    chk("rst_state", 32'(game_state), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_vga", 32'({vga_r, vga_g, vga_b}), 0);
    reset = 1'b0;
    repeat (2) @(negedge board_clk);

    // Cursor wrap in both axes.
    tap(B_LEFT);
    chk("left_row", 32'(cursor_row), 0);
    chk("left_col", 32'(cursor_col), 2);
    tap(B_UP);
    chk("up_row", 32'(cursor_row), 2);
    chk("up_col", 32'(cursor_col), 2);
    tap(B_DOWN);
    tap(B_DOWN);
    chk("down2_row", 32'(cursor_row), 1);
    chk("down2_col", 32'(cursor_col), 2);
    tap(B_UP);
    tap(B_RIGHT);
    chk("home_row", 32'(cursor_row), 0);
    chk("home_col", 32'(cursor_col), 0);
    cr = 0; cc = 0;

    // Mark and re-press an occupied cell.
    tap(B_CENTER);
    chk("mark_cell00", 32'(dut.board_reg[0]), 32'd1);
    chk("mark_player", 32'(cur_player), 1);
    tap(B_CENTER);
    chk("occ_cell00", 32'(dut.board_reg[0]), 32'd1);
    chk("occ_player", 32'(cur_player), 1);

    // P1 wins the top row.
    mark(1, 0);
    mark(0, 1);
    mark(1, 1);
    goto_cell(0, 2);
    hold(B_CENTER);
    @(negedge board_clk);
    chk("win_cell02", 32'(dut.board_reg[2]), 32'd1);
    chk("win_lag1_state", 32'(game_state), 0);
    @(negedge board_clk);
    chk("win_state", 32'(game_state), 1);
    chk("win_winner", 32'(winner), 0);
    release_btns();
    tap(B_LEFT);
    chk("win_arrow_col", 32'(cursor_col), 2);
    chk("win_arrow_state", 32'(game_state), 1);
    tap(B_CENTER);
    chk("clr_state", 32'(game_state), 0);
    chk("clr_row", 32'(cursor_row), 0);
    chk("clr_col", 32'(cursor_col), 0);
    chk("clr_player", 32'(cur_player), 0);
    chk("clr_cell02", 32'(dut.board_reg[2]), 32'd0);
    chk("clr_winner", 32'(winner), 0);
    cr = 0; cc = 0;

    // Full board with no line.
    for (int i = 0; i < 9; i++) begin
      mark(dr[i], dc[i]);
      if (i < 8) chk("draw_pending", 32'(game_state), 0);
    end
    chk("draw_state", 32'(game_state), 2);
    tap(B_CENTER);
    chk("draw_clr_state", 32'(game_state), 0);
    chk("draw_clr_row", 32'(cursor_row), 0);
    chk("draw_clr_col", 32'(cursor_col), 0);
    chk("draw_clr_player", 32'(cur_player), 0);
    chk("draw_clr_cell11", 32'(dut.board_reg[4]), 32'd0);
    cr = 0; cc = 0;

    // Pixel colours.
    pix("pix_grid", 60, 100, 1'b1, 3'b100);
    pix("pix_blank", 60, 100, 1'b0, 3'b000);
    pix("pix_cursor", 62, 62, 1'b1, 3'b010);
    mark(2, 2);
    mark(1, 1);
    pix("pix_p2", 240, 240, 1'b1, 3'b110);
    pix("pix_p1", 360, 360, 1'b1, 3'b001);
    pix("pix_vline", 180, 400, 1'b1, 3'b100);
    pix("pix_outside", 180, 430, 1'b1, 3'b000);
    @(negedge board_clk);
    pix_x = 10'd60;
    pix_y = 10'd100;
    repeat (2) @(negedge board_clk);
    chk("pix_ce_hold", 32'({vga_r, vga_g, vga_b}), 0);

    // Simultaneous up+right: only up acts.
    tap(B_UP | B_RIGHT);
    chk("prio_row", 32'(cursor_row), 0);
    chk("prio_col", 32'(cursor_col), 1);

    // Async reset between clock edges.
    pix("pre_rst_vga", 60, 100, 1'b1, 3'b100);
    @(negedge board_clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_row", 32'(cursor_row), 0);
    chk("arst_col", 32'(cursor_col), 0);
    chk("arst_player", 32'(cur_player), 0);
    chk("arst_state", 32'(game_state), 0);
    chk("arst_winner", 32'(winner), 0);
    chk("arst_vga", 32'({vga_r, vga_g, vga_b}), 0);
    chk("arst_cell22", 32'(dut.board_reg[8]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
